// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one-outstanding memory fetches and queues
// returned words with prediction metadata. Optional same-cycle bypass: define FETCH_BYPASS_EN.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [15:0] laPC,
  input  logic [15:0] predAddr,
  output logic        memReq,
  output logic [15:0] memAddr,
  input  logic        memGnt,
  input  logic        memValid,
  input  logic [15:0] memData,
  output logic        instValid,
  input  logic        instReady,
  output logic [15:0] instData,
  output logic [15:0] instPC,
  output logic        instPredTaken,
  output logic [15:0] instPredTarget,
  input  logic        redirect,
  input  logic [15:0] redirectPC
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam logic [AW:0] QFULL = (AW+1)'(QDEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t        state, stateNext;
  logic [15:0]   pc;
  logic [15:0]   ifPC, ifTarget;
  logic          ifTaken;
  logic [15:0]   qData   [QDEPTH];
  logic [15:0]   qPC     [QDEPTH];
  logic [15:0]   qTarget [QDEPTH];
  logic          qTaken  [QDEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic          fire, respOk, qEmpty, bypass, enq, deq, predTaken;

  assign laPC      = pc;
  assign memAddr   = pc;
  assign predTaken = (predAddr != 16'hFFFF);

  always_comb begin
    // The outstanding request needs no extra reservation: requests only issue from IDLE.
    memReq = resetN && (state == IDLE) && !redirect && (count < QFULL);
    fire   = memReq && memGnt;
    respOk = (state == WAIT) && memValid && !redirect;
    qEmpty = (count == '0);
`ifdef FETCH_BYPASS_EN
    bypass = respOk && qEmpty;
    enq    = respOk && !(bypass && instReady);
`else
    bypass = 1'b0;
    enq    = respOk;
`endif
    deq = !qEmpty && instReady && !redirect;

    instValid      = 1'b0;
    instData       = '0;
    instPC         = '0;
    instPredTaken  = 1'b0;
    instPredTarget = '0;
    if (!qEmpty) begin
      instValid      = 1'b1;
      instData       = qData[head];
      instPC         = qPC[head];
      instPredTaken  = qTaken[head];
      instPredTarget = qTarget[head];
    end else if (bypass) begin
      instValid      = 1'b1;
      instData       = memData;
      instPC         = ifPC;
      instPredTaken  = ifTaken;
      instPredTarget = ifTarget;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (fire) stateNext = WAIT;
      WAIT:    if (memValid) stateNext = IDLE;
               else if (redirect) stateNext = DRAIN;
      DRAIN:   if (memValid) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ifPC     <= '0;
      ifTaken  <= 1'b0;
      ifTarget <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      state <= stateNext;
      if (redirect)
        pc <= redirectPC;
      else if (fire)
        pc <= predTaken ? predAddr : pc + 16'd1;
      if (fire) begin
        ifPC     <= pc;
        ifTaken  <= predTaken;
        ifTarget <= predAddr;
      end
      if (redirect) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) tail <= tail + AW'(1);
        if (deq) head <= head + AW'(1);
        case ({enq, deq})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      qData[tail]   <= memData;
      qPC[tail]     <= ifPC;
      qTaken[tail]  <= ifTaken;
      qTarget[tail] <= ifTarget;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: one record per clock cycle of inputs and expected outputs.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [15:0] laPC, predAddr, memAddr, memData, instData, instPC, instPredTarget, redirectPC;
  logic        memReq, memGnt, memValid, instValid, instReady, instPredTaken, redirect;

  int nAsserts = 0;
  int nFail = 0;

  fetch_stage #(.RESET_PC(16'h0100), .QDEPTH(4)) dut (
    .clk(clk), .resetN(resetN), .laPC(laPC), .predAddr(predAddr),
    .memReq(memReq), .memAddr(memAddr), .memGnt(memGnt), .memValid(memValid), .memData(memData),
    .instValid(instValid), .instReady(instReady), .instData(instData), .instPC(instPC),
    .instPredTaken(instPredTaken), .instPredTarget(instPredTarget),
    .redirect(redirect), .redirectPC(redirectPC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] pred;
    logic        gnt, vld;
    logic [15:0] data;
    logic        rdy, redir;
    logic [15:0] rpc;
    logic        eReq;
    logic [15:0] eAddr;
    logic        eVal;
    logic [15:0] eData, ePC;
    logic        eTk;
    logic [15:0] eTgt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [15:0] pred, input logic gnt, input logic vld,
                     input logic [15:0] data, input logic rdy, input logic redir, input logic [15:0] rpc,
                     input logic eReq, input logic [15:0] eAddr, input logic eVal, input logic [15:0] eData,
                     input logic [15:0] ePC, input logic eTk, input logic [15:0] eTgt);
    vec_t v;
    v.rst = rst; v.pred = pred; v.gnt = gnt; v.vld = vld; v.data = data; v.rdy = rdy;
    v.redir = redir; v.rpc = rpc; v.eReq = eReq; v.eAddr = eAddr; v.eVal = eVal;
    v.eData = eData; v.ePC = ePC; v.eTk = eTk; v.eTgt = eTgt;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    nAsserts++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, nm, act, exp);
    end
  endtask

  localparam logic [15:0] NP = 16'hFFFF;

  initial begin
    memGnt = 0; memValid = 0; memData = '0; predAddr = NP; instReady = 0; redirect = 0; redirectPC = '0;
`ifdef FETCH_BYPASS_EN
    //   rst pred gnt vld data      rdy rd rpc | req addr      val data      pc        tk tgt
    add(0, NP, 0, 0, 16'h0000, 1, 0, 0,      0, 16'h0100, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 1, 0, 16'h0000, 1, 0, 0,      1, 16'h0100, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 0, 1, 16'h5555, 1, 0, 0,      0, 16'h0101, 1, 16'h5555, 16'h0100, 0, NP);
    add(1, NP, 1, 0, 16'h0000, 1, 0, 0,      1, 16'h0101, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 0, 1, 16'h6666, 0, 0, 0,      0, 16'h0102, 1, 16'h6666, 16'h0101, 0, NP);
    add(1, NP, 0, 0, 16'h0000, 1, 0, 0,      1, 16'h0102, 1, 16'h6666, 16'h0101, 0, NP);
    add(1, NP, 0, 0, 16'h0000, 1, 0, 0,      1, 16'h0102, 0, 16'h0000, 16'h0000, 0, 16'h0000);
`else
    // reset, then sequential fetch from 0x0100
    add(0, NP, 0, 0, 16'h0000, 1, 0, 0,      0, 16'h0100, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(0, NP, 1, 0, 16'h0000, 1, 0, 0,      0, 16'h0100, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 1, 0, 16'h0000, 1, 0, 0,      1, 16'h0100, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 1, 1, 16'hA000, 1, 0, 0,      0, 16'h0101, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 1, 0, 16'h0000, 1, 0, 0,      1, 16'h0101, 1, 16'hA000, 16'h0100, 0, NP);
    add(1, NP, 1, 1, 16'hA001, 1, 0, 0,      0, 16'h0102, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    // predicted branch 0x0102 -> 0x0040
    add(1, 16'h0040, 1, 0, 16'h0000, 1, 0, 0, 1, 16'h0102, 1, 16'hA001, 16'h0101, 0, NP);
    add(1, NP, 1, 1, 16'hA002, 1, 0, 0,      0, 16'h0040, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    // backpressure until the queue holds four entries
    add(1, NP, 1, 0, 16'h0000, 0, 0, 0,      1, 16'h0040, 1, 16'hA002, 16'h0102, 1, 16'h0040);
    add(1, 16'h0555, 1, 1, 16'hB000, 0, 0, 0, 0, 16'h0041, 1, 16'hA002, 16'h0102, 1, 16'h0040);
    add(1, NP, 1, 0, 16'h0000, 0, 0, 0,      1, 16'h0041, 1, 16'hA002, 16'h0102, 1, 16'h0040);
    add(1, 16'h0555, 1, 1, 16'hB001, 0, 0, 0, 0, 16'h0042, 1, 16'hA002, 16'h0102, 1, 16'h0040);
    add(1, NP, 1, 0, 16'h0000, 0, 0, 0,      1, 16'h0042, 1, 16'hA002, 16'h0102, 1, 16'h0040);
    add(1, NP, 1, 1, 16'hB002, 0, 0, 0,      0, 16'h0043, 1, 16'hA002, 16'h0102, 1, 16'h0040);
    add(1, NP, 1, 0, 16'h0000, 0, 0, 0,      0, 16'h0043, 1, 16'hA002, 16'h0102, 1, 16'h0040);
    add(1, NP, 1, 0, 16'h0000, 1, 0, 0,      0, 16'h0043, 1, 16'hA002, 16'h0102, 1, 16'h0040);
    // resume: no loss, no duplication
    add(1, NP, 1, 0, 16'h0000, 0, 0, 0,      1, 16'h0043, 1, 16'hB000, 16'h0040, 0, NP);
    add(1, NP, 0, 0, 16'h0000, 1, 0, 0,      0, 16'h0044, 1, 16'hB000, 16'h0040, 0, NP);
    add(1, NP, 0, 1, 16'hB003, 1, 0, 0,      0, 16'h0044, 1, 16'hB001, 16'h0041, 0, NP);
    add(1, NP, 0, 0, 16'h0000, 1, 0, 0,      1, 16'h0044, 1, 16'hB002, 16'h0042, 0, NP);
    add(1, NP, 0, 0, 16'h0000, 1, 0, 0,      1, 16'h0044, 1, 16'hB003, 16'h0043, 0, NP);
    add(1, NP, 0, 0, 16'h0000, 1, 0, 0,      1, 16'h0044, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    // redirect while waiting; late response is drained
    add(1, NP, 1, 0, 16'h0000, 1, 0, 0,      1, 16'h0044, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 1, 0, 16'h0000, 1, 1, 16'h0200, 0, 16'h0045, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 1, 0, 16'h0000, 1, 0, 0,      0, 16'h0200, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 1, 1, 16'hDEAD, 1, 0, 0,      0, 16'h0200, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 1, 0, 16'h0000, 1, 0, 0,      1, 16'h0200, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    // redirect coincident with response, then fall-through wrap at 0xFFFF
    add(1, NP, 1, 1, 16'h1111, 1, 1, 16'hFFFF, 0, 16'h0201, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 1, 0, 16'h0000, 1, 0, 0,      1, 16'hFFFF, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 1, 1, 16'h2222, 1, 0, 0,      0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 0, 0, 16'h0000, 1, 0, 0,      1, 16'h0000, 1, 16'h2222, 16'hFFFF, 0, NP);
    // redirect flushes a non-empty queue despite a same-cycle dequeue
    add(1, NP, 1, 0, 16'h0000, 1, 0, 0,      1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 0, 1, 16'h3333, 0, 0, 0,      0, 16'h0001, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 0, 0, 16'h0000, 1, 1, 16'h0300, 0, 16'h0001, 1, 16'h3333, 16'h0000, 0, NP);
    add(1, NP, 0, 0, 16'h0000, 1, 0, 0,      1, 16'h0300, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    // reset mid-transaction; a stale response afterwards is ignored
    add(1, NP, 1, 0, 16'h0000, 1, 0, 0,      1, 16'h0300, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(0, NP, 0, 0, 16'h0000, 1, 0, 0,      0, 16'h0100, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 0, 1, 16'h4444, 1, 0, 0,      1, 16'h0100, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, NP, 0, 0, 16'h0000, 1, 0, 0,      1, 16'h0100, 0, 16'h0000, 16'h0000, 0, 16'h0000);
`endif

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      resetN = vq[i].rst; predAddr = vq[i].pred; memGnt = vq[i].gnt; memValid = vq[i].vld;
      memData = vq[i].data; instReady = vq[i].rdy; redirect = vq[i].redir; redirectPC = vq[i].rpc;
      #1;
      chk("memReq",         i, {15'd0, memReq},        {15'd0, vq[i].eReq});
      chk("memAddr",        i, memAddr,                vq[i].eAddr);
      chk("laPC",           i, laPC,                   vq[i].eAddr);
      chk("instValid",      i, {15'd0, instValid},     {15'd0, vq[i].eVal});
      chk("instData",       i, instData,               vq[i].eData);
      chk("instPC",         i, instPC,                 vq[i].ePC);
      chk("instPredTaken",  i, {15'd0, instPredTaken}, {15'd0, vq[i].eTk});
      chk("instPredTarget", i, instPredTarget,         vq[i].eTgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
